// File: rtl/drum_pkg.sv
// Shared sizes and state encoding for the drum step sequencer.
package drum_pkg;

    localparam int unsigned NUM_VOICES = 4;
    localparam int unsigned NUM_STEPS  = 16;
    localparam int unsigned STEP_W     = $clog2(NUM_STEPS);
    localparam int unsigned VOICE_W    = $clog2(NUM_VOICES);
    localparam int unsigned PAT_W      = NUM_VOICES * NUM_STEPS;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_e;

endpackage

// File: rtl/step_timer.sv
// Counts audio ticks within a step; emits fire (first tick of step) and advance (last tick).
module step_timer #(
    parameter int unsigned SPS_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             tick_en,
    input  logic [SPS_W-1:0] samples_per_step,
    output logic             fire_c,
    output logic             advance_c
);

    logic [SPS_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [SPS_W-1:0] sps_lat_q, sps_lat_d;
    logic [SPS_W-1:0] sps_eff;
    logic             last_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            sps_lat_q  <= SPS_W'(1);
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sps_lat_q  <= sps_lat_d;
        end
    end

    // Tempo is only sampled at start and at step boundaries.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        sps_lat_d  = sps_lat_q;
        sps_eff    = (samples_per_step == '0) ? SPS_W'(1) : samples_per_step;
        last_tick  = (tick_cnt_q == (sps_lat_q - SPS_W'(1)));
        fire_c     = tick_en && (tick_cnt_q == '0);
        advance_c  = tick_en && last_tick;
        if (load) begin
            tick_cnt_d = '0;
            sps_lat_d  = sps_eff;
        end else if (tick_en) begin
            if (last_tick) begin
                tick_cnt_d = '0;
                sps_lat_d  = sps_eff;
            end else begin
                tick_cnt_d = tick_cnt_q + SPS_W'(1);
            end
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Drum-pattern scheduler: run/stop FSM, writable voice x step pattern, trigger and LED registers.
module step_sequencer
    import drum_pkg::*;
#(
    parameter int unsigned      SPS_W        = 16,
    parameter logic [PAT_W-1:0] INIT_PATTERN = '0
) (
    input  logic                  clk_150,
    input  logic                  reset_n,
    input  logic                  audio_tick,
    input  logic                  start_stop,
    input  logic [SPS_W-1:0]      samples_per_step,
    input  logic                  pat_we,
    input  logic [VOICE_W-1:0]    pat_voice,
    input  logic [STEP_W-1:0]     pat_step,
    input  logic                  pat_data,
    output logic [NUM_VOICES-1:0] trig,
    output logic [STEP_W-1:0]     step_idx,
    output logic                  running,
    output logic                  beat_led
);

    state_e                  state_q, state_d;
    logic [STEP_W-1:0]       step_idx_q, step_idx_d;
    logic [NUM_VOICES-1:0]   trig_q, trig_d;
    logic                    beat_led_q, beat_led_d;
    logic [PAT_W-1:0]        pattern_q, pattern_d;
    logic [NUM_VOICES-1:0]   column;
    logic                    tick_en;
    logic                    fire_c;
    logic                    advance_c;

    // A start/stop request swallows any coincident tick.
    assign tick_en = (state_q == ST_RUNNING) && audio_tick && !start_stop;

    step_timer #(
        .SPS_W (SPS_W)
    ) u_step_timer (
        .clk              (clk_150),
        .rst_n            (reset_n),
        .load             (start_stop),
        .tick_en          (tick_en),
        .samples_per_step (samples_per_step),
        .fire_c           (fire_c),
        .advance_c        (advance_c)
    );

    always_ff @(posedge clk_150 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_STOPPED;
            step_idx_q <= '0;
            trig_q     <= '0;
            beat_led_q <= 1'b0;
            pattern_q  <= INIT_PATTERN;
        end else begin
            state_q    <= state_d;
            step_idx_q <= step_idx_d;
            trig_q     <= trig_d;
            beat_led_q <= beat_led_d;
            pattern_q  <= pattern_d;
        end
    end

    // Pattern bit index is {voice, step}; reads use the pre-write value.
    always_comb begin
        column     = '0;
        state_d    = state_q;
        step_idx_d = step_idx_q;
        trig_d     = '0;
        pattern_d  = pattern_q;

        for (int v = 0; v < NUM_VOICES; v++) begin
            column[v] = pattern_q[{VOICE_W'(v), step_idx_q}];
        end

        if (pat_we) begin
            pattern_d[{pat_voice, pat_step}] = pat_data;
        end

        if (start_stop) begin
            state_d    = (state_q == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
            step_idx_d = '0;
        end else begin
            if (fire_c) begin
                trig_d = column;
            end
            if (advance_c) begin
                step_idx_d = step_idx_q + STEP_W'(1);
            end
        end

        beat_led_d = (state_d == ST_RUNNING) && (step_idx_d[1:0] == 2'b00);
    end

    assign trig     = trig_q;
    assign step_idx = step_idx_q;
    assign running  = (state_q == ST_RUNNING);
    assign beat_led = beat_led_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed self-checking bench for step_sequencer.
`timescale 1ns/1ps
module tb_step_sequencer;
    import drum_pkg::*;

    localparam int unsigned SPS_W = 16;

    logic                  clk_150;
    logic                  reset_n;
    logic                  audio_tick;
    logic                  start_stop;
    logic [SPS_W-1:0]      samples_per_step;
    logic                  pat_we;
    logic [VOICE_W-1:0]    pat_voice;
    logic [STEP_W-1:0]     pat_step;
    logic                  pat_data;
    logic [NUM_VOICES-1:0] trig;
    logic [STEP_W-1:0]     step_idx;
    logic                  running;
    logic                  beat_led;

    int checks;
    int errors;

    step_sequencer #(
        .SPS_W        (SPS_W),
        .INIT_PATTERN ('0)
    ) dut (
        .clk_150          (clk_150),
        .reset_n          (reset_n),
        .audio_tick       (audio_tick),
        .start_stop       (start_stop),
        .samples_per_step (samples_per_step),
        .pat_we           (pat_we),
        .pat_voice        (pat_voice),
        .pat_step         (pat_step),
        .pat_data         (pat_data),
        .trig             (trig),
        .step_idx         (step_idx),
        .running          (running),
        .beat_led         (beat_led)
    );

    initial clk_150 = 1'b0;
    always #3 clk_150 = ~clk_150;

    task automatic tick();
        @(posedge clk_150); #1 audio_tick = 1'b1;
        @(posedge clk_150); #1 audio_tick = 1'b0;
    endtask

    task automatic toggle();
        @(posedge clk_150); #1 start_stop = 1'b1;
        @(posedge clk_150); #1 start_stop = 1'b0;
    endtask

    task automatic write_cell(input int v, input int s, input logic d);
        @(posedge clk_150); #1;
        pat_we = 1'b1; pat_voice = VOICE_W'(v); pat_step = STEP_W'(s); pat_data = d;
        @(posedge clk_150); #1 pat_we = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; audio_tick = 1'b0; start_stop = 1'b0;
        samples_per_step = '0; pat_we = 1'b0; pat_voice = '0; pat_step = '0; pat_data = 1'b0;
        #20 reset_n = 1'b1;
        @(posedge clk_150); #1;
        checks++;
        if ({trig, step_idx, running, beat_led} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got trig=%b step=%0d run=%b led=%b want all 0",
                     trig, step_idx, running, beat_led);
        end
    endtask

    task automatic test_basic_bar();
        logic [STEP_W-1:0] exp_step;
        samples_per_step = SPS_W'(4);
        write_cell(0, 0, 1'b1);
        toggle();
        checks++;
        if (running !== 1'b1 || step_idx !== '0 || beat_led !== 1'b1) begin
            errors++;
            $display("FAIL start got run=%b step=%0d led=%b want 1 0 1", running, step_idx, beat_led);
        end
        for (int k = 0; k < 70; k++) begin
            tick();
            exp_step = STEP_W'(((k + 1) / 4) % 16);
            checks++;
            if (trig !== ((k % 64 == 0) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL bar_trig tick %0d got %b want %b", k, trig,
                         (k % 64 == 0) ? 4'b0001 : 4'b0000);
            end
            checks++;
            if (step_idx !== exp_step || beat_led !== (exp_step[1:0] == 2'b00)) begin
                errors++;
                $display("FAIL bar_step tick %0d got step=%0d led=%b want step=%0d", k,
                         step_idx, beat_led, exp_step);
            end
        end
        @(posedge clk_150); #1;
        checks++;
        if (trig !== '0) begin
            errors++;
            $display("FAIL trig_one_cycle got %b want 0000", trig);
        end
        toggle();
        checks++;
        if (running !== 1'b0 || step_idx !== '0 || beat_led !== 1'b0) begin
            errors++;
            $display("FAIL stop got run=%b step=%0d led=%b want 0 0 0", running, step_idx, beat_led);
        end
    endtask

    task automatic test_sps_zero();
        logic [NUM_VOICES-1:0] exp_trig;
        samples_per_step = '0;
        for (int s = 0; s < 16; s++) write_cell(1, s, 1'b1);
        toggle();
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_trig = 4'b0010 | ((k % 16 == 0) ? 4'b0001 : 4'b0000);
            checks++;
            if (trig !== exp_trig || step_idx !== STEP_W'((k + 1) % 16)) begin
                errors++;
                $display("FAIL sps0 tick %0d got trig=%b step=%0d want trig=%b step=%0d",
                         k, trig, step_idx, exp_trig, (k + 1) % 16);
            end
        end
        toggle();
    endtask

    task automatic test_stop_with_tick();
        samples_per_step = SPS_W'(4);
        toggle();
        for (int k = 0; k < 4; k++) tick();
        @(posedge clk_150); #1 audio_tick = 1'b1; start_stop = 1'b1;
        @(posedge clk_150); #1 audio_tick = 1'b0; start_stop = 1'b0;
        checks++;
        if (running !== 1'b0 || trig !== '0 || step_idx !== '0) begin
            errors++;
            $display("FAIL stop_tick got run=%b trig=%b step=%0d want 0 0000 0",
                     running, trig, step_idx);
        end
        toggle();
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (step_idx !== STEP_W'(0)) begin
            errors++;
            $display("FAIL restart_cnt3 got step=%0d want 0", step_idx);
        end
        tick();
        checks++;
        if (step_idx !== STEP_W'(1)) begin
            errors++;
            $display("FAIL restart_cnt4 got step=%0d want 1", step_idx);
        end
        toggle();
    endtask

    task automatic test_tempo_change();
        samples_per_step = SPS_W'(4);
        toggle();
        for (int k = 0; k < 9; k++) tick();
        samples_per_step = SPS_W'(8);
        tick(); tick();
        checks++;
        if (step_idx !== STEP_W'(2)) begin
            errors++;
            $display("FAIL tempo_step2_hold got step=%0d want 2", step_idx);
        end
        tick();
        checks++;
        if (step_idx !== STEP_W'(3)) begin
            errors++;
            $display("FAIL tempo_step2_len got step=%0d want 3", step_idx);
        end
        for (int k = 0; k < 7; k++) tick();
        checks++;
        if (step_idx !== STEP_W'(3)) begin
            errors++;
            $display("FAIL tempo_step3_hold got step=%0d want 3", step_idx);
        end
        tick();
        checks++;
        if (step_idx !== STEP_W'(4)) begin
            errors++;
            $display("FAIL tempo_step3_len got step=%0d want 4", step_idx);
        end
        toggle();
    endtask

    task automatic test_write_collision();
        samples_per_step = SPS_W'(1);
        toggle();
        for (int k = 0; k < 5; k++) tick();
        @(posedge clk_150); #1;
        audio_tick = 1'b1; pat_we = 1'b1; pat_voice = 2'd2; pat_step = STEP_W'(5); pat_data = 1'b1;
        @(posedge clk_150); #1 audio_tick = 1'b0; pat_we = 1'b0;
        checks++;
        if (trig[2] !== 1'b0 || step_idx !== STEP_W'(6)) begin
            errors++;
            $display("FAIL wr_collide got trig2=%b step=%0d want 0 6", trig[2], step_idx);
        end
        for (int k = 6; k < 21; k++) tick();
        tick();
        checks++;
        if (trig[2] !== 1'b1) begin
            errors++;
            $display("FAIL wr_next_bar got trig2=%b want 1", trig[2]);
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        samples_per_step = SPS_W'(4);
        for (int k = 0; k < 6; k++) tick();
        @(posedge clk_150); #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({trig, step_idx, running, beat_led} !== '0) begin
            errors++;
            $display("FAIL async_reset got trig=%b step=%0d run=%b led=%b want all 0",
                     trig, step_idx, running, beat_led);
        end
        #10 reset_n = 1'b1;
        samples_per_step = SPS_W'(1);
        toggle();
        seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (trig !== '0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_pattern got triggers=%b want 0", seen);
        end
        checks++;
        if (running !== 1'b1 || step_idx !== '0) begin
            errors++;
            $display("FAIL post_reset_run got run=%b step=%0d want 1 0", running, step_idx);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_bar();
        test_sps_zero();
        test_stop_with_tick();
        test_tempo_change();
        test_write_collision();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
